// File: rtl/mb_rx_frame_collector_if.sv
// Bundle of the frame-side signals of mb_rx_frame_collector.
//   slave  : the collector (it takes the serial stream in and drives status out)
//   master : whatever feeds the collector and consumes its results
// Serial side : Frame_Start, Serial_In, Error_In in; Select out to the CRC3 checker.
// Result side : Dout, Dout_Valid, Frame_Err, Err_Count, Frame_Count, Overrun, Busy.
interface mb_rx_frame_collector_if;
  logic       Frame_Start;
  logic       Serial_In;
  logic       Error_In;
  logic       Select;
  logic [7:0] Dout;
  logic       Dout_Valid;
  logic       Frame_Err;
  logic [7:0] Err_Count;
  logic [7:0] Frame_Count;
  logic       Overrun;
  logic       Busy;

  modport slave (
    input  Frame_Start, Serial_In, Error_In,
    output Select, Dout, Dout_Valid, Frame_Err, Err_Count, Frame_Count, Overrun, Busy
  );

  modport master (
    output Frame_Start, Serial_In, Error_In,
    input  Select, Dout, Dout_Valid, Frame_Err, Err_Count, Frame_Count, Overrun, Busy
  );
endinterface

// File: rtl/mb_rx_frame_collector.sv
// Collects one 11-bit frame (8 data bits MSB-first, then 3 CRC bits) from the
// CRC3 checker and publishes the byte plus its CRC status.
// Ports:
//   GCLK  - clock, rising edge
//   Clear - synchronous active-high reset
//   bus   - mb_rx_frame_collector_if.slave (serial input side and result outputs)
//
// state | meaning
// IDLE  | waiting for Frame_Start; its cycle captures data bit 7
// DATA  | capturing data bits 6..0 (bit counter 1..7)
// CRC   | checker in CRC-shift mode, serial bits discarded (counter 8..10)
// CHECK | sample Error_In, publish the byte on the next cycle
module mb_rx_frame_collector (
  input  logic                       GCLK,
  input  logic                       Clear,
  mb_rx_frame_collector_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, DATA, CRC, CHECK} state_t;

  state_t     state, state_nxt;
  logic [3:0] bit_cnt;
  logic [7:0] data_q;
  logic [7:0] dout_q;
  logic       dout_valid_q;
  logic       frame_err_q;
  logic [7:0] err_count_q;
  logic [7:0] frame_count_q;
  logic       overrun_q;
  logic       select_c;
  logic       busy_c;

  // state register
  always_ff @(posedge GCLK) begin
    if (Clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state; counter values outside a state's range fall back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.Frame_Start) state_nxt = DATA;
      DATA: begin
        if (bit_cnt == 4'd7)                         state_nxt = CRC;
        else if (bit_cnt == 4'd0 || bit_cnt > 4'd7)  state_nxt = IDLE;
      end
      CRC: begin
        if (bit_cnt == 4'd10)                        state_nxt = CHECK;
        else if (bit_cnt < 4'd8 || bit_cnt > 4'd10)  state_nxt = IDLE;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    select_c = 1'b1;
    busy_c   = 1'b1;
    case (state)
      IDLE:    busy_c   = 1'b0;
      CRC:     select_c = 1'b0;
      default: ;
    endcase
  end

  // datapath
  always_ff @(posedge GCLK) begin
    if (Clear) begin
      bit_cnt       <= 4'd0;
      data_q        <= 8'h00;
      dout_q        <= 8'h00;
      dout_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      err_count_q   <= 8'h00;
      frame_count_q <= 8'h00;
      overrun_q     <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (state != IDLE && bus.Frame_Start) overrun_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.Frame_Start) begin
            data_q  <= {bus.Serial_In, 7'b0};
            bit_cnt <= 4'd1;
          end
        end
        DATA: begin
          // cycle n lands in bit 7-n, i.e. the bitwise inverse of n[2:0]
          data_q[~bit_cnt[2:0]] <= bus.Serial_In;
          bit_cnt <= (state_nxt == IDLE) ? 4'd0 : bit_cnt + 4'd1;
        end
        CRC: begin
          bit_cnt <= (state_nxt == IDLE) ? 4'd0 : bit_cnt + 4'd1;
        end
        CHECK: begin
          dout_q        <= data_q;
          frame_err_q   <= bus.Error_In;
          dout_valid_q  <= 1'b1;
          frame_count_q <= frame_count_q + 8'd1;
          if (bus.Error_In && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
          bit_cnt <= 4'd0;
        end
        default: bit_cnt <= 4'd0;
      endcase
    end
  end

  assign bus.Select      = select_c;
  assign bus.Busy        = busy_c;
  assign bus.Dout        = dout_q;
  assign bus.Dout_Valid  = dout_valid_q;
  assign bus.Frame_Err   = frame_err_q;
  assign bus.Err_Count   = err_count_q;
  assign bus.Frame_Count = frame_count_q;
  assign bus.Overrun     = overrun_q;

endmodule

// File: tb/tb_mb_rx_frame_collector.sv
module tb_mb_rx_frame_collector;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  logic [7:0] exp_dout;
  logic       exp_fe;
  logic [7:0] exp_fc;
  logic [7:0] exp_ec;
  logic       exp_ov;

  mb_rx_frame_collector_if bus ();

  mb_rx_frame_collector dut (
    .GCLK  (clk),
    .Clear (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_select",  32'(bus.Select),      32'd1);
    check("rst_busy",    32'(bus.Busy),        32'd0);
    check("rst_dout",    32'(bus.Dout),        32'h00);
    check("rst_dv",      32'(bus.Dout_Valid),  32'd0);
    check("rst_fe",      32'(bus.Frame_Err),   32'd0);
    check("rst_ec",      32'(bus.Err_Count),   32'd0);
    check("rst_fc",      32'(bus.Frame_Count), 32'd0);
    check("rst_ov",      32'(bus.Overrun),     32'd0);
    exp_dout = 8'h00; exp_fe = 1'b0; exp_fc = 8'h00; exp_ec = 8'h00; exp_ov = 1'b0;
  endtask

  // Starts at the negedge of cycle 0 and returns at the negedge of cycle 12,
  // so another call right away gives back-to-back frames.
  task automatic do_frame(input logic [7:0] d, input logic err, input int fs_at);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      check("select", 32'(bus.Select), (c >= 8 && c <= 10) ? 32'd0 : 32'd1);
      if (c > 0) begin
        check("busy",      32'(bus.Busy),       32'd1);
        check("dv_early",  32'(bus.Dout_Valid), 32'd0);
        check("dout_hold", 32'(bus.Dout),       32'(exp_dout));
        check("fe_hold",   32'(bus.Frame_Err),  32'(exp_fe));
      end else begin
        check("busy_idle", 32'(bus.Busy), 32'd0);
      end
      clr             = 1'b0;
      bus.Frame_Start = (c == 0) || (c == fs_at);
      bus.Serial_In   = (c < 8) ? d[7-c] : 1'($urandom);
      bus.Error_In    = (c == 11) ? err : ~err;
    end
    @(negedge clk);
    bus.Frame_Start = 1'b0;
    if (fs_at > 0) exp_ov = 1'b1;
    exp_fc   = exp_fc + 8'd1;
    if (err && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
    exp_dout = d;
    exp_fe   = err;
    check("dv_pulse",    32'(bus.Dout_Valid),  32'd1);
    check("dout",        32'(bus.Dout),        32'(exp_dout));
    check("frame_err",   32'(bus.Frame_Err),   32'(exp_fe));
    check("frame_count", 32'(bus.Frame_Count), 32'(exp_fc));
    check("err_count",   32'(bus.Err_Count),   32'(exp_ec));
    check("overrun",     32'(bus.Overrun),     32'(exp_ov));
  endtask

  initial begin
    logic [7:0] abort_byte;
    checks = 0;
    errors = 0;
    clr = 1'b1;
    bus.Frame_Start = 1'b0;
    bus.Serial_In   = 1'b0;
    bus.Error_In    = 1'b0;

    // reset
    repeat (2) @(negedge clk);
    check_reset_values();
    clr = 1'b0;

    // idle noise must be ignored
    for (int i = 0; i < 3; i++) begin
      bus.Serial_In = 1'($urandom);
      bus.Error_In  = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(bus.Busy),       32'd0);
      check("idle_dv",   32'(bus.Dout_Valid), 32'd0);
      check("idle_ec",   32'(bus.Err_Count),  32'd0);
    end

    // clean frame 0xA5, then errored frame 0xA5
    do_frame(8'hA5, 1'b0, -1);
    @(negedge clk);
    check("dv_one_cycle", 32'(bus.Dout_Valid), 32'd0);
    check("dout_held",    32'(bus.Dout),       32'hA5);
    do_frame(8'hA5, 1'b1, -1);
    check("a5_err_dout", 32'(bus.Dout), 32'hA5);

    // Frame_Start during DATA: frame continues, overrun sticks
    do_frame(8'hC3, 1'b0, 5);
    repeat (3) @(negedge clk);
    check("ov_sticky", 32'(bus.Overrun),    32'd1);
    check("ov_dv",     32'(bus.Dout_Valid), 32'd0);

    // clear, then 256 back-to-back errored frames
    clr = 1'b1;
    @(negedge clk);
    check_reset_values();
    for (int i = 0; i < 256; i++) begin
      do_frame(8'(i * 7 + 1), 1'b1, -1);
    end
    check("fc_wrap", 32'(bus.Frame_Count), 32'd0);
    check("ec_sat",  32'(bus.Err_Count),   32'd255);

    // abort a 0xFF frame with Clear at cycle 6, then receive 0x3C
    abort_byte = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      bus.Frame_Start = (c == 0);
      bus.Serial_In   = abort_byte[7-c];
      bus.Error_In    = 1'b1;
    end
    @(negedge clk);
    bus.Frame_Start = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    check_reset_values();
    do_frame(8'h3C, 1'b0, -1);
    check("post_clr_ov", 32'(bus.Overrun), 32'd0);
    @(negedge clk);
    check("final_dv", 32'(bus.Dout_Valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mb_rx_frame_collector.md
MB_RX_FRAME_COLLECTOR -- requirements
Module: mb_rx_frame_collector

Interface
REQ-001 SHALL provide port GCLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL provide port Clear, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL provide port Frame_Start, input, 1 bit: high for one cycle alongside the first (MSB) data bit on Serial_In.
REQ-004 SHALL provide port Serial_In, input, 1 bit: serial stream from the CRC3 checker Serial_Out, 8 data bits MSB-first, then 3 CRC bits.
REQ-005 SHALL provide port Error_In, input, 1 bit: CRC3 checker ERROR output.
REQ-006 SHALL provide port Select, output, 1 bit: CRC3 checker mode select; 1 = data pass, 0 = CRC shift.
REQ-007 SHALL provide port Dout, output, 8 bits: last received data byte.
REQ-008 SHALL provide port Dout_Valid, output, 1 bit: one-cycle pulse marking Dout and Frame_Err as updated.
REQ-009 SHALL provide port Frame_Err, output, 1 bit: CRC error status of the last frame.
REQ-010 SHALL provide port Err_Count, output, 8 bits: count of errored frames, saturating.
REQ-011 SHALL provide port Frame_Count, output, 8 bits: count of completed frames, wrapping.
REQ-012 SHALL provide port Overrun, output, 1 bit: sticky flag for a Frame_Start seen while busy.
REQ-013 SHALL provide port Busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, DATA, CRC and CHECK.
REQ-015 SHALL, in IDLE with Frame_Start=1 (cycle 0), shift Serial_In into data register bit 7, go to DATA, and load the bit counter with 1.
REQ-016 SHALL, in DATA (cycles 1-7), shift Serial_In in MSB-first (cycle n fills bit 7-n) and go to CRC after cycle 7.
REQ-017 SHALL stay in CRC for exactly 3 cycles (8-10) and discard Serial_In there.
REQ-018 SHALL, in CHECK (cycle 11), sample Error_In and then return to IDLE.
REQ-019 SHALL drive Select=0 only in CRC and Select=1 in IDLE, DATA and CHECK.
REQ-020 SHALL, at the end of cycle 11, register Dout = assembled byte and Frame_Err = sampled Error_In, so that Dout_Valid=1 during cycle 12 only; latency is 12 cycles from Frame_Start to Dout_Valid.
REQ-021 SHALL hold Dout and Frame_Err stable between Dout_Valid pulses.
REQ-022 SHALL increment Frame_Count by 1 per completed frame, wrapping 255 -> 0.
REQ-023 SHALL increment Err_Count by 1 per frame with Frame_Err=1, saturating at 255.
REQ-024 SHALL ignore Frame_Start in DATA, CRC and CHECK (no restart, frame unaffected) and set Overrun=1, which holds until Clear.
REQ-025 SHALL accept Frame_Start in IDLE in the same cycle that Dout_Valid is high, giving a minimum frame period of 12 cycles.
REQ-026 SHALL ignore Serial_In and Error_In in IDLE when Frame_Start=0.
REQ-027 SHALL keep the bit counter at 4 bits, with unused values returning the FSM to IDLE.

Reset
REQ-028 SHALL, with Clear=1 at a clock edge, force state IDLE, Select=1, Dout=8'h00, Dout_Valid=0, Frame_Err=0, Err_Count=0, Frame_Count=0, Overrun=0, Busy=0 and bit counter=0.
REQ-029 SHALL let Clear take priority over Frame_Start and abort a frame in progress without emitting Dout_Valid.
REQ-030 SHALL accept a new Frame_Start on the first edge after Clear deasserts.

Verification
REQ-031 SHALL pass: Frame_Start at cycle 0, bits 1,0,1,0,0,1,0,1 then 3 CRC bits, Error_In=0 at cycle 11 -> Dout=8'hA5, Frame_Err=0, Dout_Valid high in cycle 12 only, Frame_Count=1, Err_Count=0.
REQ-032 SHALL pass: same frame with Error_In=1 at cycle 11 -> Frame_Err=1, Err_Count=1, Dout=8'hA5.
REQ-033 SHALL pass: 256 back-to-back frames every 12 cycles, all errored -> Frame_Count=0 (wrapped), Err_Count=255, no dropped Dout_Valid.
REQ-034 SHALL pass: Frame_Start reasserted at cycle 5 -> frame completes normally at cycle 12 and Overrun=1 remains set afterwards.
REQ-035 SHALL pass: Clear=1 at cycle 6 of a frame -> no Dout_Valid, all outputs at reset values, next frame 8'h3C received correctly.
REQ-036 SHALL pass: Select observed as 1 in cycles 0-7, 0 in cycles 8-10, and 1 in cycle 11 onward.
